// File: rtl/seq_piso_serializer_if.sv
// Word-input handshake plus serial-output bundle for the PISO feeder.
// The master side produces words; the slave side is the serializer.
interface seq_piso_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             ser_out;
    logic             ser_valid;
    logic [1:0]       fifo_level;

    modport master (
        output din, din_valid,
        input  din_ready, ser_out, ser_valid, fifo_level
    );

    modport slave (
        input  din, din_valid,
        output din_ready, ser_out, ser_valid, fifo_level
    );
endinterface

// File: rtl/seq_piso_serializer.sv
// Parallel-in/serial-out feeder: 2-word FIFO in front of a shift register,
// streaming words one bit per clock with no gap between consecutive words.
module seq_piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    seq_piso_serializer_if.slave bus
);
    localparam int unsigned     RemW    = $clog2(WIDTH + 1);
    localparam logic [RemW-1:0] RemOne  = RemW'(1);
    localparam logic [RemW-1:0] RemFull = RemW'(WIDTH);

    logic [WIDTH-1:0] fifo_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       level_q;
    logic [WIDTH-1:0] shreg_q;
    logic [RemW-1:0]  rem_q;
    logic             ser_out_q;
    logic             ser_valid_q;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    assign bus.din_ready  = (level_q < 2'd2) && rst;
    assign bus.ser_out    = ser_out_q;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.fifo_level = level_q;

    assign push = bus.din_valid && bus.din_ready;
    // Pop uses the pre-edge level, so a word pushed into an empty FIFO waits one cycle.
    assign pop  = (rem_q <= RemOne) && (level_q != 2'd0);
    assign head = fifo_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            level_q     <= 2'd0;
            shreg_q     <= '0;
            rem_q       <= '0;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= bus.din;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push && !pop) begin
                level_q <= level_q + 2'd1;
            end else if (!push && pop) begin
                level_q <= level_q - 2'd1;
            end

            if (rem_q > RemOne) begin
                rem_q <= rem_q - RemOne;
                if (MSB_FIRST) begin
                    shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
                    ser_out_q <= shreg_q[WIDTH-2];
                end else begin
                    shreg_q   <= {1'b0, shreg_q[WIDTH-1:1]};
                    ser_out_q <= shreg_q[1];
                end
            end else if (pop) begin
                shreg_q     <= head;
                rem_q       <= RemFull;
                ser_valid_q <= 1'b1;
                ser_out_q   <= MSB_FIRST ? head[WIDTH-1] : head[0];
            end else begin
                rem_q       <= '0;
                ser_valid_q <= 1'b0;
                ser_out_q   <= IDLE_BIT;
            end
        end
    end
endmodule

// File: tb/tb_seq_piso_serializer.sv
// Bench for seq_piso_serializer: two instances (5-bit MSB-first idle 0, 8-bit LSB-first idle 1)
// checked against a bit-queue reference model by a negedge monitor.
module tb_seq_piso_serializer;
    logic clk;
    logic rst;

    seq_piso_serializer_if #(.WIDTH(5)) bus5 ();
    seq_piso_serializer_if #(.WIDTH(8)) bus8 ();

    seq_piso_serializer #(.WIDTH(5), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    seq_piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    int wd [2]   = '{5, 8};
    bit msb [2]  = '{1'b1, 1'b0};
    bit idle [2] = '{1'b0, 1'b1};

    logic [31:0] din_s [2];
    logic        dv_s  [2];
    logic        rdy_s [2];
    logic        so_s  [2];
    logic        sv_s  [2];
    logic [1:0]  lvl_s [2];

    assign din_s[0] = 32'(bus5.din);
    assign din_s[1] = 32'(bus8.din);
    assign dv_s[0]  = bus5.din_valid;
    assign dv_s[1]  = bus8.din_valid;
    assign rdy_s[0] = bus5.din_ready;
    assign rdy_s[1] = bus8.din_ready;
    assign so_s[0]  = bus5.ser_out;
    assign so_s[1]  = bus8.ser_out;
    assign sv_s[0]  = bus5.ser_valid;
    assign sv_s[1]  = bus8.ser_valid;
    assign lvl_s[0] = bus5.fifo_level;
    assign lvl_s[1] = bus8.fifo_level;

    // Reference model: bits still to be shown, in emission order, per instance.
    bit          exp_q [2][$];
    bit          staged [2];
    logic [31:0] staged_w [2];

    task automatic check(input string name, input int u, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s unit%0d t=%0t: got %0h expected %0h", name, u, $time, got, exp);
        end
    endtask

    initial begin
        staged = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                bit ev;
                bit eb;
                int exp_lvl;
                bit exp_rdy;
                if (!rst) begin
                    exp_q[u].delete();
                    staged[u] = 1'b0;
                    ev        = 1'b0;
                    eb        = idle[u];
                    exp_lvl   = 0;
                    exp_rdy   = 1'b0;
                end else begin
                    if (exp_q[u].size() > 0) begin
                        ev = 1'b1;
                        eb = exp_q[u].pop_front();
                    end else begin
                        ev = 1'b0;
                        eb = idle[u];
                    end
                    // A word accepted at the edge just past becomes visible one edge later.
                    if (staged[u]) begin
                        for (int i = 0; i < wd[u]; i++) begin
                            exp_q[u].push_back(msb[u] ? staged_w[u][wd[u]-1-i] : staged_w[u][i]);
                        end
                        staged[u] = 1'b0;
                    end
                    exp_lvl = exp_q[u].size() / wd[u];
                    exp_rdy = (exp_lvl < 2);
                end
                check("ser_valid", u, 32'(sv_s[u]), 32'(ev));
                check("ser_out", u, 32'(so_s[u]), 32'(eb));
                check("fifo_level", u, 32'(lvl_s[u]), 32'(exp_lvl));
                check("din_ready", u, 32'(rdy_s[u]), 32'(exp_rdy));
                staged[u]   = rst && dv_s[u] && exp_rdy;
                staged_w[u] = din_s[u];
            end
        end
    end

    task automatic set_in(input int u, input logic v, input logic [31:0] w);
        if (u == 0) begin
            bus5.din_valid = v;
            bus5.din       = w[4:0];
        end else begin
            bus8.din_valid = v;
            bus8.din       = w[7:0];
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the word valid until accepted; called just after a rising edge.
    task automatic push_word(input int u, input logic [31:0] w);
        int n;
        n = 0;
        set_in(u, 1'b1, w);
        @(negedge clk);
        while (!rdy_s[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("push_timeout", u, 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        set_in(u, 1'b0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 1'b1, 32'h16);
        set_in(1, 1'b1, 32'hA5);
        #1 rst = 1'b0;
        cycles(2);
        #1 rst = 1'b1;
        set_in(0, 1'b0, 32'd0);
        set_in(1, 1'b0, 32'd0);
        cycles(2);

        push_word(0, 32'b10110);
        cycles(8);
        push_word(0, 32'b10110);
        push_word(0, 32'b10110);
        cycles(14);
        push_word(1, 32'hA5);
        cycles(12);

        push_word(0, 32'h0A);
        push_word(0, 32'h1B);
        push_word(0, 32'h0C);
        push_word(0, 32'h1D);
        cycles(24);

        for (int c = 0; c < 400; c++) begin
            for (int u = 0; u < 2; u++) begin
                set_in(u, ($urandom_range(0, 3) != 0), $urandom);
            end
            cycles(1);
        end
        set_in(0, 1'b0, 32'd0);
        set_in(1, 1'b0, 32'd0);
        cycles(40);

        push_word(0, 32'h13);
        push_word(0, 32'h0E);
        cycles(2);
        rst = 1'b0;
        cycles(2);
        rst = 1'b1;
        cycles(1);
        push_word(0, 32'h19);
        cycles(12);

        for (int u = 0; u < 2; u++) begin
            check("drained", u, 32'(exp_q[u].size()), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
